// File: rtl/bcd_pkg.sv
// Shared BCD constants, digit type and digit-range helper for the BCD adder slice.
package bcd_pkg;

   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_CORR = 4'd6;

   typedef logic [3:0] bcd_digit_t;

   function automatic logic digit_invalid(input bcd_digit_t d);
      return (d > BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit combinational BCD adder: decimal-corrected sum and carry-out.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [4:0] sum_s;
   logic [3:0] corr_s;

   // Binary sum, then +6 correction (mod 16) whenever the sum leaves the decimal range.
   always_comb begin
      sum_s  = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
      corr_s = sum_s[3:0] + BCD_CORR;
      if (sum_s > {1'b0, BCD_MAX}) begin
         s  = corr_s;
         co = 1'b1;
      end else begin
         s  = sum_s[3:0];
         co = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_adder.sv
// Registered NDIG-digit BCD adder built from a rippled chain of bcd_digit_add.
// Optional invalid-digit flag on err is enabled by defining BCD_ADDER_ERR_EN.
module bcd_adder
   import bcd_pkg::*;
#(
   parameter int NDIG = 1
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [4*NDIG-1:0] in1,
   input  logic [4*NDIG-1:0] in2,
   input  logic              Cin,
   output logic [4*NDIG-1:0] out,
   output logic              Cout,
   output logic              out_valid,
   output logic              err
);

   logic [NDIG:0]     carry_s;
   logic [4*NDIG-1:0] sum_s;

   assign carry_s[0] = Cin;

   for (genvar k = 0; k < NDIG; k++) begin : g_digit
      bcd_digit_add u_digit (
         .a  (in1[4*k +: 4]),
         .b  (in2[4*k +: 4]),
         .ci (carry_s[k]),
         .s  (sum_s[4*k +: 4]),
         .co (carry_s[k+1])
      );
   end

   // Result and valid registers; results hold while no new operands arrive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out       <= '0;
         Cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out  <= sum_s;
            Cout <= carry_s[NDIG];
         end
      end
   end

`ifdef BCD_ADDER_ERR_EN
   logic err_s;

   // Flag any operand digit outside 0..9.
   always_comb begin
      err_s = 1'b0;
      for (int k = 0; k < NDIG; k++) begin
         err_s = err_s | digit_invalid(in1[4*k +: 4]) | digit_invalid(in2[4*k +: 4]);
      end
   end

   // Error flag register, updated alongside the sum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (in_valid) begin
         err <= err_s;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_adder.sv
// Self-checking bench for bcd_adder: directed vectors, randomized back-to-back
// traffic against a per-digit decimal reference model, hold and async reset.
module tb_bcd_adder;

`ifdef BCD_ADDER_ERR_EN
   localparam bit ERR_ON = 1'b1;
`else
   localparam bit ERR_ON = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       cin;
   logic [3:0] a1, b1, o1;
   logic [7:0] a2, b2, o2;
   logic       co1, co2, ov1, ov2, e1, e2;

   int checks   = 0;
   int failures = 0;

   bcd_adder #(.NDIG(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in1(a1), .in2(b1), .Cin(cin),
      .out(o1), .Cout(co1), .out_valid(ov1), .err(e1)
   );

   bcd_adder #(.NDIG(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in1(a2), .in2(b2), .Cin(cin),
      .out(o2), .Cout(co2), .out_valid(ov2), .err(e2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Reference: digit-serial decimal addition from the arithmetic rule.
   // Returns {err, cout, sum[31:0]}.
   function automatic logic [33:0] ref_add(input int nd, input logic [31:0] a,
                                           input logic [31:0] b, input logic c);
      int          carry;
      int          s;
      int          da, db;
      logic [31:0] res;
      logic        e;
      carry = int'(c);
      res   = 32'd0;
      e     = 1'b0;
      for (int k = 0; k < nd; k++) begin
         da = int'(a[4*k +: 4]);
         db = int'(b[4*k +: 4]);
         if (da > 9 || db > 9) e = 1'b1;
         s = da + db + carry;
         if (s > 9) begin
            res[4*k +: 4] = 4'((s + 6) % 16);
            carry = 1;
         end else begin
            res[4*k +: 4] = 4'(s);
            carry = 0;
         end
      end
      return {e & ERR_ON, (carry == 1), res};
   endfunction

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; cin = 1'b0;
      a1 = 4'd0; b1 = 4'd0; a2 = 8'd0; b2 = 8'd0;
      repeat (2) @(negedge clk);
      checks++;
      if ({o1, co1, ov1, e1} !== 7'd0) begin
         failures++;
         $display("FAIL reset_dut1: got out=%h cout=%b ov=%b err=%b want all 0", o1, co1, ov1, e1);
      end
      checks++;
      if ({o2, co2, ov2, e2} !== 11'd0) begin
         failures++;
         $display("FAIL reset_dut2: got out=%h cout=%b ov=%b err=%b want all 0", o2, co2, ov2, e2);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed_one_digit();
      logic [3:0] ta [8] = '{4'd0, 4'd4, 4'd2, 4'd3, 4'd9, 4'd0, 4'd15, 4'd10};
      logic [3:0] tb [8] = '{4'd5, 4'd9, 4'd9, 4'd8, 4'd9, 4'd9, 4'd15, 4'd0};
      logic       tc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [3:0] eo [8] = '{4'd5, 4'd3, 4'd1, 4'd1, 4'd9, 4'd0, 4'd5, 4'd0};
      logic       ec [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      logic       ee [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 8; i++) begin
         a1 = ta[i]; b1 = tb[i]; cin = tc[i]; a2 = 8'd0; b2 = 8'd0; in_valid = 1'b1;
         @(negedge clk);
         checks++;
         if (o1 !== eo[i] || co1 !== ec[i] || ov1 !== 1'b1 || e1 !== (ee[i] & ERR_ON)) begin
            failures++;
            $display("FAIL dir1_%0d: %0d+%0d+%b got out=%0d cout=%b ov=%b err=%b want out=%0d cout=%b ov=1 err=%b",
                     i, ta[i], tb[i], tc[i], o1, co1, ov1, e1, eo[i], ec[i], ee[i] & ERR_ON);
         end
      end
      // after an out-of-range digit, a clean operand pair clears err
      a1 = 4'd3; b1 = 4'd4; cin = 1'b0;
      @(negedge clk);
      checks++;
      if (o1 !== 4'd7 || co1 !== 1'b0 || e1 !== 1'b0) begin
         failures++;
         $display("FAIL dir1_err_clear: got out=%0d cout=%b err=%b want out=7 cout=0 err=0", o1, co1, e1);
      end
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed_two_digit();
      logic [7:0] ta [3] = '{8'h99, 8'h45, 8'h99};
      logic [7:0] tb [3] = '{8'h01, 8'h38, 8'h99};
      logic       tc [3] = '{1'b0, 1'b0, 1'b1};
      logic [7:0] eo [3] = '{8'h00, 8'h83, 8'h99};
      logic       ec [3] = '{1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         a2 = ta[i]; b2 = tb[i]; cin = tc[i]; a1 = 4'd0; b1 = 4'd0; in_valid = 1'b1;
         @(negedge clk);
         checks++;
         if (o2 !== eo[i] || co2 !== ec[i] || ov2 !== 1'b1) begin
            failures++;
            $display("FAIL dir2_%0d: %h+%h+%b got out=%h cout=%b ov=%b want out=%h cout=%b ov=1",
                     i, ta[i], tb[i], tc[i], o2, co2, ov2, eo[i], ec[i]);
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random_back_to_back();
      logic [33:0] r1, r2;
      logic [3:0]  x1o;
      logic [7:0]  x2o;
      logic        x1c, x2c, x1e, x2e, xv;
      logic        wild;
      // last committed results still on the outputs
      x1o = o1; x1c = co1; x1e = e1; x2o = o2; x2c = co2; x2e = e2; xv = 1'b0;
      for (int i = 0; i < 300; i++) begin
         wild = ($urandom_range(0, 7) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         cin = 1'($urandom_range(0, 1));
         a1 = wild ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
         b1 = wild ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
         a2 = {4'($urandom_range(0, 9)), wild ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9))};
         b2 = {wild ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         r1 = ref_add(1, {28'd0, a1}, {28'd0, b1}, cin);
         r2 = ref_add(2, {24'd0, a2}, {24'd0, b2}, cin);
         xv = in_valid;
         if (in_valid) begin
            x1o = r1[3:0]; x1c = r1[32]; x1e = r1[33];
            x2o = r2[7:0]; x2c = r2[32]; x2e = r2[33];
         end
         @(negedge clk);
         checks++;
         if (o1 !== x1o || co1 !== x1c || e1 !== x1e || ov1 !== xv) begin
            failures++;
            $display("FAIL rand1_%0d: got out=%h cout=%b err=%b ov=%b want out=%h cout=%b err=%b ov=%b",
                     i, o1, co1, e1, ov1, x1o, x1c, x1e, xv);
         end
         checks++;
         if (o2 !== x2o || co2 !== x2c || e2 !== x2e || ov2 !== xv) begin
            failures++;
            $display("FAIL rand2_%0d: got out=%h cout=%b err=%b ov=%b want out=%h cout=%b err=%b ov=%b",
                     i, o2, co2, e2, ov2, x2o, x2c, x2e, xv);
         end
      end
   endtask

   task automatic test_hold();
      a1 = 4'd6; b1 = 4'd7; a2 = 8'h27; b2 = 8'h18; cin = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a1 = 4'($urandom_range(0, 9)); b1 = 4'($urandom_range(0, 9));
         a2 = 8'($urandom_range(0, 255)); cin = 1'($urandom_range(0, 1));
         @(negedge clk);
         checks++;
         if (o1 !== 4'd4 || co1 !== 1'b1 || ov1 !== 1'b0) begin
            failures++;
            $display("FAIL hold1_%0d: got out=%0d cout=%b ov=%b want out=4 cout=1 ov=0", i, o1, co1, ov1);
         end
         checks++;
         if (o2 !== 8'h46 || co2 !== 1'b0 || ov2 !== 1'b0) begin
            failures++;
            $display("FAIL hold2_%0d: got out=%h cout=%b ov=%b want out=46 cout=0 ov=0", i, o2, co2, ov2);
         end
      end
   endtask

   task automatic test_async_reset();
      a1 = 4'd3; b1 = 4'd4; a2 = 8'h95; b2 = 8'h05; cin = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (o1 !== 4'd7 || ov1 !== 1'b1 || o2 !== 8'h00 || co2 !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset: got out1=%0d ov1=%b out2=%h cout2=%b want 7 1 00 1", o1, ov1, o2, co2);
      end
      // assert mid-cycle, well before the next rising edge
      #2 rst = 1'b1;
      #1;
      checks++;
      if (o1 !== 4'd0 || co1 !== 1'b0 || ov1 !== 1'b0 || o2 !== 8'h00 || co2 !== 1'b0 || ov2 !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: got out1=%0d cout1=%b ov1=%b out2=%h cout2=%b ov2=%b want all 0",
                  o1, co1, ov1, o2, co2, ov2);
      end
      a1 = 4'd9; b1 = 4'd9; in_valid = 1'b1;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (ov1 !== 1'b0 || o1 !== 4'd0 || ov2 !== 1'b0) begin
         failures++;
         $display("FAIL reset_discard: got ov1=%b out1=%0d ov2=%b want ov1=0 out1=0 ov2=0", ov1, o1, ov2);
      end
      a1 = 4'd2; b1 = 4'd2; cin = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (ov1 !== 1'b1 || o1 !== 4'd4 || co1 !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_first: got ov=%b out=%0d cout=%b want ov=1 out=4 cout=0", ov1, o1, co1);
      end
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_directed_one_digit();
      test_directed_two_digit();
      test_random_back_to_back();
      test_hold();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
